// File: rtl/inverter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inverter_pipe
// Description : Pipelined multi-channel bitwise inverter with valid/ready flow
//               control and a clock-enable stall. Every lane is XORed with the
//               same invert mask on entry. The beat then travels through
//               LATENCY register stages and reaches the output.
//
//               Optional feature macro: INVERTER_MASK_EN
//                 defined   : the mask is a DATA_WIDTH register. It resets to
//                             all-ones and is loaded from mask_in when
//                             mask_wr is high.
//                 undefined : the mask is the constant all-ones, so the block
//                             does a plain inversion. mask_in and mask_wr are
//                             ignored.
//
// Ports       :
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   en         in   clock enable; low freezes all pipeline state
//   in_valid   in   input beat present
//   in_ready   out  the pipeline accepts a beat this cycle
//   data_in    in   NUM_CHANNELS lanes; lane c is at [c*DATA_WIDTH +: DATA_WIDTH]
//   mask_in    in   new invert mask (INVERTER_MASK_EN only)
//   mask_wr    in   load mask_in (INVERTER_MASK_EN only)
//   out_valid  out  output beat present
//   out_ready  in   the consumer accepts the output beat
//   data_out   out  inverted data, with the same lane packing as data_in
//
// Revision    : 1.0 - initial release
// ============================================================================
module inverter_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 1,
    parameter int LATENCY      = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0]              mask_in,
    input  logic                               mask_wr,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out
);

    localparam int c_BUS_W = NUM_CHANNELS * DATA_WIDTH;

    logic                  w_advance;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [c_BUS_W-1:0]    w_mask_bus;

    logic                  r_valid [LATENCY];
    logic [c_BUS_W-1:0]    r_data  [LATENCY];

    // The whole pipeline moves as one unit. A valid beat parked at the
    // output stage with no taker blocks every stage, including any bubbles
    // upstream of it. Bubbles are deliberately not collapsed, so the latency
    // stays fixed.
    assign w_advance = rst & en & (~out_valid | out_ready);
    assign in_ready  = w_advance;

`ifdef INVERTER_MASK_EN
    logic [DATA_WIDTH-1:0] r_mask;

    // This register is not gated by en. A mask write still takes effect
    // while the pipeline is frozen. A beat accepted on the same edge as the
    // write sees the old value, because it reads r_mask before the update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mask <= '1;
        end else if (mask_wr) begin
            r_mask <= mask_in;
        end
    end

    assign w_mask = r_mask;
`else
    logic w_unused;

    assign w_mask   = '1;
    assign w_unused = ^{mask_in, mask_wr};
`endif

    // Replicate the single mask across every lane.
    genvar g_c;
    generate
        for (g_c = 0; g_c < NUM_CHANNELS; g_c++) begin : g_lane
            assign w_mask_bus[g_c*DATA_WIDTH +: DATA_WIDTH] = w_mask;
        end
    endgenerate

    // The data registers load on every advance, including bubbles. This
    // keeps data_out at a defined, previously loaded value at all times.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            r_data[0]  <= data_in ^ w_mask_bus;
            for (int k = 1; k < LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign data_out  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_inverter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_inverter_pipe
// Description : Self-checking bench for inverter_pipe. Configuration:
//               DATA_WIDTH=8, NUM_CHANNELS=2, LATENCY=2.
//               A reference model checks the outputs every cycle. The model
//               treats the pipeline as a delay line of advance events: the
//               output shows whatever entered LATENCY advances ago.
//               Directed scenarios pin literal values; random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inverter_pipe;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   data_in;
    logic [7:0]    mask_in;
    logic          mask_wr;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   data_out;

    int total = 0;
    int bad   = 0;

    inverter_pipe #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .LATENCY(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .mask_in   (mask_in),
        .mask_wr   (mask_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Each entry is {valid, data}. The model holds
    // exactly L entries, and the oldest entry is what the output must
    // show. All inputs are stable at the falling edge, so the model
    // predicts the coming rising edge here.
    // ------------------------------------------------------------------
    logic [16:0] hist[$];
    logic [7:0]  mmask       = 8'hFF;
    bit          seen_reset  = 1'b0;
    bit          prev_rst_lo = 1'b0;

    always @(negedge clk) begin
        logic [16:0] e;
        logic        adv;
        if (seen_reset) begin
            e = hist[0];
            chk("out_valid", out_valid, e[16]);
            if (e[16]) chk("data_out", data_out, e[15:0]);
            if (prev_rst_lo) chk("data_out_after_reset", data_out, 0);
            adv = rst && en && (!out_valid || out_ready);
            chk("in_ready", in_ready, adv);
        end
        if (!rst) begin
            hist.delete();
            for (int k = 0; k < L; k++) hist.push_back(17'h0);
            mmask      = 8'hFF;
            seen_reset = 1'b1;
        end else if (seen_reset) begin
            if (en && (!out_valid || out_ready)) begin
                void'(hist.pop_front());
                hist.push_back({in_valid, data_in ^ {mmask, mmask}});
            end
`ifdef INVERTER_MASK_EN
            if (mask_wr) mmask = mask_in;
`endif
        end
        prev_rst_lo = !rst;
    end

    // ------------------------------------------------------------------
    // Directed stream driver. Per-cycle patterns control out_ready, en,
    // rst and mask_wr. A beat moves on only after a handshake. Outputs
    // are sampled at the falling edge, and transferred beats are
    // collected in outl.
    // ------------------------------------------------------------------
    logic [15:0] stim [8];
    int          nstim;
    bit          orr [24];
    bit          enp [24];
    bit          rstp[24];
    bit          mwr [24];
    logic [7:0]  min_v;
    logic        obs_v[24];
    logic        obs_r[24];
    logic [15:0] obs_d[24];
    logic [15:0] outl[$];

    task automatic clear_pat();
        for (int c = 0; c < 24; c++) begin
            orr[c] = 1'b1; enp[c] = 1'b1; rstp[c] = 1'b1; mwr[c] = 1'b0;
        end
        min_v = 8'h00;
    endtask

    task automatic stream(input int ncyc);
        int idx = 0;
        outl.delete();
        for (int c = 0; c < ncyc; c++) begin
            rst       = rstp[c];
            en        = enp[c];
            out_ready = orr[c];
            in_valid  = (idx < nstim);
            data_in   = (idx < nstim) ? stim[idx] : 16'h0;
            mask_wr   = mwr[c];
            mask_in   = min_v;
            @(negedge clk);
            obs_v[c] = out_valid;
            obs_r[c] = in_ready;
            obs_d[c] = data_out;
            if (out_valid && out_ready && en && rst) outl.push_back(data_out);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_outl(input string name, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3,
                            input logic [15:0] e4, input int n);
        logic [15:0] ev[5];
        ev = '{e0, e1, e2, e3, e4};
        chk({name, "_count"}, outl.size(), n);
        for (int i = 0; i < n; i++)
            if (i < outl.size()) chk(name, outl[i], ev[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for 3 cycles while input is offered.
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; data_in = 16'h1234;
        mask_in = 8'h00; mask_wr = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_data_out", data_out, 16'h0000);
            chk("rst_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_beat", out_valid, 0);
        end
        @(posedge clk); #1;

        // Back-to-back beats at full throughput.
        clear_pat();
        stim[0] = 16'h55AA; stim[1] = 16'h0000; stim[2] = 16'hFFFF; nstim = 3;
        stream(7);
        chk("thru_v1", obs_v[1], 0);
        chk("thru_v2", obs_v[2], 1);
        chk("thru_v3", obs_v[3], 1);
        chk("thru_v4", obs_v[4], 1);
        chk("thru_v5", obs_v[5], 0);
        chk("thru_d2", obs_d[2], 16'hAA55);
        chk_outl("thru", 16'hAA55, 16'hFFFF, 16'h0000, 16'h0, 16'h0, 3);

        // Output backpressure for 4 cycles.
        clear_pat();
        for (int i = 0; i < 5; i++) stim[i] = 16'h0102 + 16'(i);
        nstim = 5;
        for (int c = 2; c < 6; c++) orr[c] = 1'b0;
        stream(12);
        for (int c = 2; c < 6; c++) begin
            chk("bp_in_ready", obs_r[c], 0);
            chk("bp_hold_v", obs_v[c], 1);
            chk("bp_hold_d", obs_d[c], 16'hFEFD);
        end
        chk_outl("bp", 16'hFEFD, 16'hFEFC, 16'hFEFB, 16'hFEFA, 16'hFEF9, 5);

        // Clock-enable low for 3 cycles.
        clear_pat();
        stim[0] = 16'h1111; stim[1] = 16'h2222; stim[2] = 16'h3333; stim[3] = 16'h4444;
        nstim = 4;
        for (int c = 1; c < 4; c++) enp[c] = 1'b0;
        stream(11);
        for (int c = 1; c < 4; c++) chk("en_in_ready", obs_r[c], 0);
        chk("en_v4", obs_v[4], 0);
        chk("en_v5", obs_v[5], 1);
        chk("en_d5", obs_d[5], 16'hEEEE);
        chk_outl("en", 16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h0, 4);

        // Mask write. The beat accepted on the write edge keeps the old mask.
        clear_pat();
        stim[0] = 16'h55AA; stim[1] = 16'h55AA; nstim = 2;
        mwr[0] = 1'b1; min_v = 8'h0F;
        stream(5);
`ifdef INVERTER_MASK_EN
        chk_outl("mask", 16'hAA55, 16'h5AA5, 16'h0, 16'h0, 16'h0, 2);
`else
        chk_outl("mask", 16'hAA55, 16'hAA55, 16'h0, 16'h0, 16'h0, 2);
`endif

        // Reset pulse with two beats in flight. The head beat is stalled,
        // so it is never taken.
        clear_pat();
        stim[0] = 16'h1357; stim[1] = 16'h2468; stim[2] = 16'h55AA; nstim = 3;
        orr[2] = 1'b0; rstp[2] = 1'b0;
        stream(7);
        chk("rp_v3", obs_v[3], 0);
        chk("rp_d3", obs_d[3], 16'h0000);
        chk("rp_v5", obs_v[5], 1);
        chk_outl("rp", 16'hAA55, 16'h0, 16'h0, 16'h0, 16'h0, 1);

        // Random traffic checked by the model.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(99) != 0);
            en        = ($urandom_range(9) != 0);
            out_ready = en ? ($urandom_range(9) < 7) : 1'b0;
            in_valid  = ($urandom_range(9) < 7);
            data_in   = 16'($urandom);
            mask_wr   = ($urandom_range(9) == 0);
            mask_in   = 8'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; in_valid = 1'b0; mask_wr = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inverter_pipe.md
# inverter_pipe

Parametrised, pipelined multi-channel bitwise inverter with valid/ready flow control, clock-enable stall and an optional runtime-programmable invert mask. It is the registered successor to the combinational inverter primitive, for datapaths that need N parallel lanes, a fixed configurable latency and backpressure. It sits inline on streaming buses between producers and consumers in the primitives library.

## Interface
- DATA_WIDTH, 32, bits per channel (≥1)
- NUM_CHANNELS, 1, number of parallel lanes (≥1)
- LATENCY, 2, pipeline stages from accept to output (≥1)

One clock; reset is synchronous and active-low.
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- en  input  1  clock enable; low freezes pipeline state
- in_valid  input  1  input beat present
- in_ready  output  1  pipeline accepts a beat this cycle
- data_in  input  NUM_CHANNELS*DATA_WIDTH  lane c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- mask_in  input  DATA_WIDTH  new invert mask (INVERTER_MASK_EN only)
- mask_wr  input  1  load mask_in (INVERTER_MASK_EN only)
- out_valid  output  1  output beat present
- out_ready  input  1  consumer accepts output beat
- data_out  output  NUM_CHANNELS*DATA_WIDTH  inverted data, same lane packing

## Operation
- advance = rst && en && (!out_valid || out_ready); in_ready = advance (combinational).
- On advance: stage[0] <= {in_valid, data_in ^ {NUM_CHANNELS{mask}}}; stage[k] <= stage[k-1] for k=1..LATENCY-1.
- out_valid / data_out = valid and data of stage[LATENCY-1], registered.
- Input beat accepted iff in_valid && in_ready; output beat transferred iff out_valid && out_ready.
- No advance: every stage holds (valid and data). Bubbles are not collapsed; they travel through the pipeline.
- Same mask applied identically to every lane; without INVERTER_MASK_EN mask is constant all-ones (plain inversion).
- Data registers of invalid stages are don't-care internally but data_out must show the last loaded value, never X.
- Beats leave in acceptance order; no loss, no duplication under any out_ready/en pattern.

## Timing
- Reset (rst=0 at clock edge): all stage valid bits 0, all stage data 0, out_valid=0, data_out=0, mask=all-ones. in_ready=0 while rst=0.
- Latency: beat accepted at edge T appears on out_valid/data_out after edge T+LATENCY−1 (visible in cycle T+LATENCY-1 to T+LATENCY) if every intervening cycle advances; each stalled cycle adds one.
- Throughput: one beat per cycle while out_ready=1 and en=1.
- en=0: no state change including valid bits; in_ready=0; outputs stable. mask_wr still honoured.
- out_valid=1 with out_ready=0: full stall, in_ready=0, data_out stable until transfer.
- mask_wr at edge T: new mask used for beats accepted at edge T+1 onward; beat accepted at edge T uses old mask. Beats already in pipeline are unaffected.
- Reset mid-operation: in-flight beats discarded, mask reverts to all-ones, same values as power-on reset.
- mask_wr while rst=0: ignored.

## Configuration
- INVERTER_MASK_EN defined: mask register of DATA_WIDTH bits, loaded from mask_in on mask_wr, reset to all-ones; output = data ^ mask per lane.
- INVERTER_MASK_EN undefined: no mask register; mask_in and mask_wr remain as ports but are ignored; output = ~data per lane.

## Test plan
(DATA_WIDTH=8, NUM_CHANNELS=2, LATENCY=2, out_ready=1, en=1 unless stated)
- Hold rst=0 for 3 cycles with in_valid=1, data_in=0x1234 -> out_valid=0, data_out=0x0000, in_ready=0 throughout; no beat appears after release until new input.
- Release reset, drive data_in 0x55AA, 0x0000, 0xFFFF on consecutive cycles -> out_valid high for 3 consecutive cycles starting 2 cycles after first accept, data_out 0xAA55, 0xFFFF, 0x0000.
- Stream 0x0102..0x0106, hold out_ready=0 for 4 cycles after first output -> in_ready=0, data_out held at 0xFEFD; on release outputs 0xFEFD..0xFEF9 in order, none lost or repeated.
- Toggle en low for 3 cycles mid-stream -> valid bits, data_out and in_ready frozen; stream resumes unchanged with exactly 3 cycles extra latency.
- INVERTER_MASK_EN: mask_wr with mask_in=0x0F, next cycle send 0x55AA -> data_out 0x5AA5; beat accepted on the mask_wr edge still yields full inversion; without macro, same stimulus -> 0xAA55.
- Pulse rst=0 for one cycle with 2 beats in flight and mask=0x0F -> out_valid=0 next cycle, in-flight beats never appear, subsequent 0x55AA -> 0xAA55 (mask back to 0xFF).
